// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - load-use stall, taken-branch flush and run/halt/step sequencing
// for the 5-stage pipeline.
module pipeline_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter bit IGNORE_R0 = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             halt_req,
  input  logic             step_req,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             exmem_pcsrc,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic             step_ack,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {S_RUN, S_HALT, S_STEP} state_t;

  state_t state, state_nxt;
  logic   load_use;
  logic   stall_evt;
  logic   flush_evt;

  assign load_use = idex_memread
                  & ((idex_rt == ifid_rs) | (idex_rt == ifid_rt))
                  & ~(IGNORE_R0 & (idex_rt == 5'd0));

  always_comb begin
    state_nxt   = state;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    stall_evt   = 1'b0;
    flush_evt   = 1'b0;

    if (state == S_HALT) begin
      // Bubbles keep draining the back end; a branch resolving now still redirects the PC.
      idex_flush = 1'b1;
      if (exmem_pcsrc) begin
        pc_write    = 1'b1;
        ifid_flush  = 1'b1;
        exmem_flush = 1'b1;
        flush_evt   = 1'b1;
      end
      if (step_req)
        state_nxt = S_STEP;
      else if (enable && !halt_req)
        state_nxt = S_RUN;
    end else begin
      if (exmem_pcsrc) begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        flush_evt   = 1'b1;
      end else if (load_use) begin
        idex_flush = 1'b1;
        stall_evt  = 1'b1;
      end else begin
        pc_write   = 1'b1;
        ifid_write = 1'b1;
      end

      if (state == S_STEP) begin
        // A step is only consumed once the instruction actually advances.
        if (!stall_evt)
          state_nxt = S_HALT;
      end else if (halt_req || !enable) begin
        state_nxt = S_HALT;
      end
    end

    if (reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_HALT;
      halted      <= 1'b1;
      step_ack    <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      state    <= state_nxt;
      halted   <= (state_nxt == S_HALT);
      step_ack <= (state == S_STEP) && (state_nxt == S_HALT);
      if (stall_evt && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + CNT_W'(1);
      if (flush_evt && (flush_count != {CNT_W{1'b1}}))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
